// File: rtl/zuse_muldiv_if.sv
// Command/operand/result bundle between the FPU host control FSM (master)
// and the zuse_muldiv datapath (slave).
interface zuse_muldiv_if #(
   parameter int MANT_W = 15,
   parameter int EXP_W  = 7
);
   logic              mul;
   logic              div;
   logic              reg1_s;
   logic [EXP_W-1:0]  reg1_e;
   logic [MANT_W-1:0] reg1_m;
   logic              reg2_s;
   logic [EXP_W-1:0]  reg2_e;
   logic [MANT_W-1:0] reg2_m;
   logic              res_s;
   logic [EXP_W-1:0]  res_e;
   logic [MANT_W-1:0] res_m;
   logic              zero_flag;
   logic              overflow_flag;
   logic              underflow_flag;
   logic              idle;

   modport master (
      output mul, div, reg1_s, reg1_e, reg1_m, reg2_s, reg2_e, reg2_m,
      input  res_s, res_e, res_m, zero_flag, overflow_flag, underflow_flag, idle
   );

   modport slave (
      input  mul, div, reg1_s, reg1_e, reg1_m, reg2_s, reg2_e, reg2_m,
      output res_s, res_e, res_m, zero_flag, overflow_flag, underflow_flag, idle
   );
endinterface

// File: rtl/zuse_muldiv.sv
// Sequential multiply/divide for the 1/7/15 Zuse-style float format:
// shift-add multiply and restoring divide, one mantissa bit per clock.
module zuse_muldiv #(
   parameter int MANT_W = 15,
   parameter int EXP_W  = 7
) (
   input logic          clk,
   input logic          rst_n,
   zuse_muldiv_if.slave bus
);
   localparam int SIG_W  = MANT_W + 1;
   localparam int PROD_W = 2 * SIG_W;
   localparam int Q_W    = SIG_W + 1;
   localparam int XE_W   = EXP_W + 2;
   localparam int CNT_W  = $clog2(Q_W);

   localparam logic [EXP_W-1:0]        EXP_ZERO = {1'b1, {(EXP_W-1){1'b0}}};
   localparam logic [EXP_W-1:0]        EXP_INF  = {1'b0, {(EXP_W-1){1'b1}}};
   localparam logic signed [XE_W-1:0]  EXP_MAX  = XE_W'((2 ** (EXP_W-1)) - 2);
   localparam logic signed [XE_W-1:0]  EXP_MIN  = XE_W'(1 - (2 ** (EXP_W-1)));
   localparam logic [CNT_W-1:0]        MUL_LAST = CNT_W'(SIG_W - 1);
   localparam logic [CNT_W-1:0]        DIV_LAST = CNT_W'(SIG_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_ITER  = 2'd2,
      S_NORM  = 2'd3
   } state_t;

   state_t                   r_state, w_state_nxt;
   logic                     r_op_div, w_op_div_nxt;
   logic                     r_sign, w_sign_nxt;
   logic [EXP_W-1:0]         r_ea, w_ea_nxt, r_eb, w_eb_nxt;
   logic [SIG_W-1:0]         r_ma, w_ma_nxt, r_mb, w_mb_nxt;
   logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
   logic signed [XE_W-1:0]   r_exp, w_exp_nxt;
   logic [PROD_W-1:0]        r_prod, w_prod_nxt;
   logic [Q_W-1:0]           r_rem, w_rem_nxt, r_q, w_q_nxt;
   logic                     r_res_s, w_res_s_nxt;
   logic [EXP_W-1:0]         r_res_e, w_res_e_nxt;
   logic [MANT_W-1:0]        r_res_m, w_res_m_nxt;
   logic                     r_zero, w_zero_nxt, r_ovf, w_ovf_nxt, r_unf, w_unf_nxt;
   logic                     r_idle, w_idle_nxt;

   logic                     w_za, w_zb, w_ia, w_ib;
   logic                     w_undef, w_tozero, w_toinf;
   logic signed [XE_W-1:0]   w_xea, w_xeb, w_exp_ck, w_fexp;
   logic [SIG_W:0]           w_madd;
   logic [PROD_W-1:0]        w_mshift;
   logic                     w_dge;
   logic [SIG_W-1:0]         w_dsub;
   logic [Q_W-1:0]           w_drem;
   logic                     w_mul_hi, w_div_hi;
   logic [MANT_W-1:0]        w_frac;

   // Operand classification and exponent combination for the CHECK state.
   assign w_za     = (r_ea == EXP_ZERO);
   assign w_zb     = (r_eb == EXP_ZERO);
   assign w_ia     = (r_ea == EXP_INF);
   assign w_ib     = (r_eb == EXP_INF);
   assign w_undef  = r_op_div ? ((w_za & w_zb) | (w_ia & w_ib)) : ((w_za & w_ib) | (w_ia & w_zb));
   assign w_tozero = r_op_div ? (w_za | w_ib) : (w_za | w_zb);
   assign w_toinf  = r_op_div ? (w_ia | w_zb) : (w_ia | w_ib);
   assign w_xea    = {{2{r_ea[EXP_W-1]}}, r_ea};
   assign w_xeb    = {{2{r_eb[EXP_W-1]}}, r_eb};
   assign w_exp_ck = r_op_div ? (w_xea - w_xeb) : (w_xea + w_xeb);

   // One shift-add step: add multiplicand into the upper half, then shift right.
   assign w_madd   = r_prod[0] ? ({1'b0, r_prod[PROD_W-1:SIG_W]} + {1'b0, r_ma})
                               : {1'b0, r_prod[PROD_W-1:SIG_W]};
   assign w_mshift = {w_madd, r_prod[SIG_W-1:1]};

   // Restoring step; the remainder stays below twice the divisor.
   assign w_dge  = (r_rem >= {1'b0, r_mb});
   assign w_dsub = r_rem[SIG_W-1:0] - r_mb;
   assign w_drem = w_dge ? {w_dsub, 1'b0} : {r_rem[Q_W-2:0], 1'b0};

   // Normalisation: at most one position of adjustment for either op.
   assign w_mul_hi = r_prod[PROD_W-1];
   assign w_div_hi = r_q[Q_W-1];
   assign w_fexp   = r_op_div ? (r_exp - {{(XE_W-1){1'b0}}, ~w_div_hi})
                              : (r_exp + {{(XE_W-1){1'b0}}, w_mul_hi});
   assign w_frac   = r_op_div ? (w_div_hi ? r_q[Q_W-2:1] : r_q[Q_W-3:0])
                              : (w_mul_hi ? r_prod[PROD_W-2 -: MANT_W] : r_prod[PROD_W-3 -: MANT_W]);

   // Next-state and next-datapath logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_op_div_nxt = r_op_div;
      w_sign_nxt   = r_sign;
      w_ea_nxt     = r_ea;
      w_eb_nxt     = r_eb;
      w_ma_nxt     = r_ma;
      w_mb_nxt     = r_mb;
      w_cnt_nxt    = r_cnt;
      w_exp_nxt    = r_exp;
      w_prod_nxt   = r_prod;
      w_rem_nxt    = r_rem;
      w_q_nxt      = r_q;
      w_res_s_nxt  = r_res_s;
      w_res_e_nxt  = r_res_e;
      w_res_m_nxt  = r_res_m;
      w_zero_nxt   = r_zero;
      w_ovf_nxt    = r_ovf;
      w_unf_nxt    = r_unf;
      w_idle_nxt   = r_idle;
      case (r_state)
         S_IDLE: begin
            if (bus.mul || bus.div) begin
               w_op_div_nxt = ~bus.mul;
               w_sign_nxt   = bus.reg1_s ^ bus.reg2_s;
               w_ea_nxt     = bus.reg1_e;
               w_eb_nxt     = bus.reg2_e;
               w_ma_nxt     = {1'b1, bus.reg1_m};
               w_mb_nxt     = {1'b1, bus.reg2_m};
               w_cnt_nxt    = {CNT_W{1'b0}};
               w_idle_nxt   = 1'b0;
               w_state_nxt  = S_CHECK;
            end else begin
               w_state_nxt  = S_IDLE;
            end
         end
         S_CHECK: begin
            if (w_undef || w_tozero) begin
               w_res_s_nxt = 1'b0;
               w_res_e_nxt = EXP_ZERO;
               w_res_m_nxt = {MANT_W{1'b0}};
               w_zero_nxt  = 1'b1;
               w_ovf_nxt   = w_undef;
               w_unf_nxt   = 1'b0;
               w_idle_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_toinf) begin
               w_res_s_nxt = r_sign;
               w_res_e_nxt = EXP_INF;
               w_res_m_nxt = {MANT_W{1'b0}};
               w_zero_nxt  = 1'b0;
               w_ovf_nxt   = 1'b1;
               w_unf_nxt   = 1'b0;
               w_idle_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_exp_nxt   = w_exp_ck;
               w_prod_nxt  = {{SIG_W{1'b0}}, r_mb};
               w_rem_nxt   = {1'b0, r_ma};
               w_q_nxt     = {Q_W{1'b0}};
               w_state_nxt = S_ITER;
            end
         end
         S_ITER: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_op_div) begin
               w_rem_nxt   = w_drem;
               w_q_nxt     = {r_q[Q_W-2:0], w_dge};
               w_state_nxt = (r_cnt == DIV_LAST) ? S_NORM : S_ITER;
            end else begin
               w_prod_nxt  = w_mshift;
               w_state_nxt = (r_cnt == MUL_LAST) ? S_NORM : S_ITER;
            end
         end
         S_NORM: begin
            w_idle_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
            if (w_fexp > EXP_MAX) begin
               w_res_s_nxt = r_sign;
               w_res_e_nxt = EXP_INF;
               w_res_m_nxt = {MANT_W{1'b0}};
               w_zero_nxt  = 1'b0;
               w_ovf_nxt   = 1'b1;
               w_unf_nxt   = 1'b0;
            end else if (w_fexp < EXP_MIN) begin
               w_res_s_nxt = 1'b0;
               w_res_e_nxt = EXP_ZERO;
               w_res_m_nxt = {MANT_W{1'b0}};
               w_zero_nxt  = 1'b1;
               w_ovf_nxt   = 1'b0;
               w_unf_nxt   = 1'b1;
            end else begin
               w_res_s_nxt = r_sign;
               w_res_e_nxt = w_fexp[EXP_W-1:0];
               w_res_m_nxt = w_frac;
               w_zero_nxt  = 1'b0;
               w_ovf_nxt   = 1'b0;
               w_unf_nxt   = 1'b0;
            end
         end
         default: begin
            w_idle_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_op_div <= 1'b0;
         r_sign   <= 1'b0;
         r_ea     <= {EXP_W{1'b0}};
         r_eb     <= {EXP_W{1'b0}};
         r_ma     <= {SIG_W{1'b0}};
         r_mb     <= {SIG_W{1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
         r_exp    <= {XE_W{1'b0}};
         r_prod   <= {PROD_W{1'b0}};
         r_rem    <= {Q_W{1'b0}};
         r_q      <= {Q_W{1'b0}};
         r_res_s  <= 1'b0;
         r_res_e  <= {EXP_W{1'b0}};
         r_res_m  <= {MANT_W{1'b0}};
         r_zero   <= 1'b0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_idle   <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_op_div <= w_op_div_nxt;
         r_sign   <= w_sign_nxt;
         r_ea     <= w_ea_nxt;
         r_eb     <= w_eb_nxt;
         r_ma     <= w_ma_nxt;
         r_mb     <= w_mb_nxt;
         r_cnt    <= w_cnt_nxt;
         r_exp    <= w_exp_nxt;
         r_prod   <= w_prod_nxt;
         r_rem    <= w_rem_nxt;
         r_q      <= w_q_nxt;
         r_res_s  <= w_res_s_nxt;
         r_res_e  <= w_res_e_nxt;
         r_res_m  <= w_res_m_nxt;
         r_zero   <= w_zero_nxt;
         r_ovf    <= w_ovf_nxt;
         r_unf    <= w_unf_nxt;
         r_idle   <= w_idle_nxt;
      end
   end

   assign bus.res_s          = r_res_s;
   assign bus.res_e          = r_res_e;
   assign bus.res_m          = r_res_m;
   assign bus.zero_flag      = r_zero;
   assign bus.overflow_flag  = r_ovf;
   assign bus.underflow_flag = r_unf;
   assign bus.idle           = r_idle;
endmodule

// File: tb/tb_zuse_muldiv.sv
// Directed plus randomized bench for zuse_muldiv against an arithmetic model
// of the 1/7/15 float format.
module tb_zuse_muldiv;
   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   zuse_muldiv_if #(.MANT_W(15), .EXP_W(7)) bus ();

   zuse_muldiv #(.MANT_W(15), .EXP_W(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        s;
      logic [6:0]  e;
      logic [14:0] m;
      logic        z;
      logic        o;
      logic        u;
      logic [5:0]  lat;
   } exp_t;

   function automatic logic [22:0] fp(input logic s, input logic [6:0] e, input logic [14:0] m);
      return {s, e, m};
   endfunction

   // Reference: value = (-1)^s * 1.m * 2^e, worked out with integer arithmetic.
   function automatic exp_t model(input bit is_div, input logic [22:0] a, input logic [22:0] b);
      exp_t   r;
      int     ea, eb, e;
      longint sa, sb, p, q;
      bit     za, zb, ia, ib;
      r    = '0;
      ea   = int'($signed(a[21:15]));
      eb   = int'($signed(b[21:15]));
      za   = (ea == -64);
      zb   = (eb == -64);
      ia   = (ea == 63);
      ib   = (eb == 63);
      r.s  = a[22] ^ b[22];
      r.lat = 6'd1;
      if (is_div ? ((za && zb) || (ia && ib)) : ((za && ib) || (ia && zb))) begin
         r.s = 1'b0; r.e = 7'h40; r.z = 1'b1; r.o = 1'b1;
         return r;
      end
      if (is_div ? (za || ib) : (za || zb)) begin
         r.s = 1'b0; r.e = 7'h40; r.z = 1'b1;
         return r;
      end
      if (is_div ? (ia || zb) : (ia || ib)) begin
         r.e = 7'h3F; r.o = 1'b1;
         return r;
      end
      sa = 64'd32768 + longint'(a[14:0]);
      sb = 64'd32768 + longint'(b[14:0]);
      if (!is_div) begin
         r.lat = 6'd18;
         p = sa * sb;
         e = ea + eb;
         if (p >= 64'd2147483648) begin
            e++;
            r.m = 15'((p >> 16) % 32768);
         end else begin
            r.m = 15'((p >> 15) % 32768);
         end
      end else begin
         r.lat = 6'd19;
         q = (sa * 65536) / sb;
         e = ea - eb;
         if (q >= 64'd65536) begin
            r.m = 15'((q >> 1) % 32768);
         end else begin
            e--;
            r.m = 15'(q % 32768);
         end
      end
      if (e > 62) begin
         r.e = 7'h3F; r.m = 15'h0; r.o = 1'b1;
      end else if (e < -63) begin
         r.s = 1'b0; r.e = 7'h40; r.m = 15'h0; r.z = 1'b1; r.u = 1'b1;
      end else begin
         r.e = 7'(e);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic run_op(input bit is_div, input logic [22:0] a, input logic [22:0] b, input bit noise);
      exp_t e;
      int   lat;
      bit   done;
      e = model(is_div, a, b);
      @(negedge clk);
      bus.mul = ~is_div;
      bus.div = is_div;
      {bus.reg1_s, bus.reg1_e, bus.reg1_m} = a;
      {bus.reg2_s, bus.reg2_e, bus.reg2_m} = b;
      @(posedge clk);
      #1;
      chk("idle_drop", 32'(bus.idle), 32'd0);
      @(negedge clk);
      bus.mul = 1'b0;
      bus.div = 1'b0;
      lat  = 0;
      done = 1'b0;
      for (int n = 1; n <= 40 && !done; n++) begin
         @(posedge clk);
         #1;
         if (bus.idle) begin
            done = 1'b1;
            lat  = n;
         end else if (noise && n == 4) begin
            bus.mul = 1'b1;
            bus.div = 1'b1;
            {bus.reg1_s, bus.reg1_e, bus.reg1_m} = 23'($urandom);
            {bus.reg2_s, bus.reg2_e, bus.reg2_m} = 23'($urandom);
         end else if (noise && n == 5) begin
            bus.mul = 1'b0;
            bus.div = 1'b0;
         end
      end
      bus.mul = 1'b0;
      bus.div = 1'b0;
      vectors++;
      chk("latency", 32'(lat), 32'(e.lat));
      chk("res_s", 32'(bus.res_s), 32'(e.s));
      chk("res_e", 32'(bus.res_e), 32'(e.e));
      chk("res_m", 32'(bus.res_m), 32'(e.m));
      chk("zero_flag", 32'(bus.zero_flag), 32'(e.z));
      chk("overflow_flag", 32'(bus.overflow_flag), 32'(e.o));
      chk("underflow_flag", 32'(bus.underflow_flag), 32'(e.u));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_idle"}, 32'(bus.idle), 32'd1);
      chk({tag, "_res"}, 32'({bus.res_s, bus.res_e, bus.res_m}), 32'd0);
      chk({tag, "_flags"}, 32'({bus.zero_flag, bus.overflow_flag, bus.underflow_flag}), 32'd0);
   endtask

   function automatic logic [22:0] rnd_normal();
      logic [6:0] e;
      e = 7'($urandom_range(0, 125) - 63);
      return fp(1'($urandom), e, 15'($urandom));
   endfunction

   initial begin
      logic [22:0] a, b;
      bus.mul = 1'b0;
      bus.div = 1'b0;
      {bus.reg1_s, bus.reg1_e, bus.reg1_m} = 23'd0;
      {bus.reg2_s, bus.reg2_e, bus.reg2_m} = 23'd0;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #2;
      vectors++;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_op(1'b0, fp(1'b0, 7'h00, 15'h4000), fp(1'b0, 7'h00, 15'h4000), 1'b0);
      run_op(1'b1, fp(1'b0, 7'h01, 15'h4000), fp(1'b1, 7'h00, 15'h4000), 1'b0);
      run_op(1'b0, fp(1'b0, 7'h3E, 15'h0000), fp(1'b0, 7'h3E, 15'h0000), 1'b0);
      run_op(1'b0, fp(1'b0, 7'h41, 15'h0000), fp(1'b0, 7'h7F, 15'h0000), 1'b0);
      run_op(1'b1, fp(1'b0, 7'h00, 15'h0000), fp(1'b0, 7'h40, 15'h1234), 1'b0);
      run_op(1'b1, fp(1'b1, 7'h40, 15'h0001), fp(1'b0, 7'h40, 15'h7FFF), 1'b0);
      run_op(1'b0, fp(1'b1, 7'h40, 15'h0000), fp(1'b0, 7'h3F, 15'h0000), 1'b0);
      run_op(1'b1, fp(1'b0, 7'h3F, 15'h0000), fp(1'b1, 7'h3F, 15'h0000), 1'b0);
      run_op(1'b0, fp(1'b1, 7'h3F, 15'h0000), fp(1'b0, 7'h05, 15'h2222), 1'b0);
      run_op(1'b1, fp(1'b1, 7'h10, 15'h5555), fp(1'b0, 7'h3F, 15'h0000), 1'b0);
      run_op(1'b1, fp(1'b1, 7'h10, 15'h5555), fp(1'b0, 7'h40, 15'h0000), 1'b0);
      run_op(1'b0, fp(1'b1, 7'h7F, 15'h7FFF), fp(1'b1, 7'h7F, 15'h7FFF), 1'b0);
      run_op(1'b1, fp(1'b0, 7'h00, 15'h0000), fp(1'b0, 7'h00, 15'h7FFF), 1'b0);
      run_op(1'b0, fp(1'b0, 7'h03, 15'h6000), fp(1'b1, 7'h7E, 15'h1000), 1'b1);

      // Abort a multiply mid-flight: stray div pulse at edge 5, reset after edge 10.
      @(negedge clk);
      bus.mul = 1'b1;
      {bus.reg1_s, bus.reg1_e, bus.reg1_m} = fp(1'b0, 7'h02, 15'h1111);
      {bus.reg2_s, bus.reg2_e, bus.reg2_m} = fp(1'b1, 7'h01, 15'h2222);
      @(posedge clk);
      @(negedge clk);
      bus.mul = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk);
         #1;
         if (n == 4) bus.div = 1'b1;
         else bus.div = 1'b0;
      end
      vectors++;
      chk("busy_before_rst", 32'(bus.idle), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort");
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, fp(1'b0, 7'h00, 15'h4000), fp(1'b1, 7'h00, 15'h4000), 1'b0);

      for (int i = 0; i < 160; i++) begin
         a = rnd_normal();
         b = rnd_normal();
         run_op(1'($urandom), a, b, (i % 16) == 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/zuse_muldiv.md
Name: zuse_muldiv

Overview:
- Sequential multiply/divide datapath for the 1/7/15 Zuse-style float format used by the UART-controlled FPU.
- Sits directly downstream of the host control FSM, inside the fpu, beside the add/sub path.
- Takes single-cycle mul/div command pulses plus operand registers. Returns the result, zero/overflow/underflow flags and an idle handshake.
- Mantissa multiply is shift-add. Division is restoring. Both run one bit per clock.

Parameters:
- MANT_W, 15: stored fraction bits; the hidden leading 1 is implicit.
- EXP_W, 7: two's-complement exponent width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- mul  in  1  start-multiply pulse, sampled only in IDLE
- div  in  1  start-divide pulse, sampled only in IDLE
- reg1_s  in  1  operand A sign
- reg1_e  in  EXP_W  operand A exponent
- reg1_m  in  MANT_W  operand A fraction
- reg2_s, reg2_e, reg2_m  in  1/EXP_W/MANT_W  operand B (divisor)
- res_s  out  1  result sign
- res_e  out  EXP_W  result exponent
- res_m  out  MANT_W  result fraction
- zero_flag  out  1  result is zero
- overflow_flag  out  1  result is infinity or undefined
- underflow_flag  out  1  exponent underflowed to zero
- idle  out  1  high when ready and the result is valid

Behaviour:
- Encoding:
  - value = (-1)^s * 1.m * 2^e, with e signed.
  - e = -64 (7'h40) encodes zero; m is ignored.
  - e = +63 (7'h3F) encodes infinity; m is ignored.
  - Normal exponent range is -63..62.
- Reset (async, rst_n=0): state IDLE; idle=1; res_s=0; res_e=0; res_m=0; all flags 0. Reset mid-operation aborts the operation; the partial result is discarded.
- States: IDLE, CHECK, ITER, NORM.
- IDLE:
  - On mul or div = 1: latch both operands, the op (mul wins if both are high) and the sign s1^s2. Clear the internal counter.
  - Next state CHECK; idle goes 0 at the same edge.
  - Operand changes after the start edge have no effect.
- CHECK: computes the 9-bit signed exponent sum (mul: eA+eB) or difference (div: eA-eB). Special cases write the result and return to IDLE:
  - mul 0*inf, div 0/0, div inf/inf: res = zero encoding, sign 0, zero_flag=1, overflow_flag=1.
  - Zero operand, or div x/inf: zero encoding, sign 0, zero_flag=1.
  - inf operand, or div x/0: infinity, sign s1^s2, m=0, overflow_flag=1.
  - Otherwise go to ITER.
- ITER, mul: 16 cycles. Shift-add of 16-bit 1.mA by 16-bit 1.mB into a 32-bit product.
- ITER, div: 17 cycles. Restoring division of 1.mA by 1.mB gives a 17-bit quotient q in (0.5, 2).
- NORM (1 cycle):
  - mul: if product[31]=1, shift right 1 and exp+1. The fraction is the next 15 bits below the leading 1; truncate (round toward zero).
  - div: if q[16]=0, shift left 1 and exp-1. The fraction is the 15 bits below the leading 1; truncate.
  - Final exp > 62: infinity, overflow_flag=1.
  - Final exp < -63: zero encoding, sign 0, zero_flag=1, underflow_flag=1.
  - Else the normal result with all flags 0.
  - Next state IDLE; idle=1.
- Latency, counted from the start-sampling edge E0 to the edge that raises idle:
  - special case: 1 edge (E1);
  - mul: 18 edges;
  - div: 19 edges.
- Result and flags are written only on completion. They hold until the next completion; no partial values ever appear on the outputs.
- mul/div pulses while idle=0 are ignored; no queuing.

Test Plan:
- A=(0,0,15'h4000) 1.5, B=1.5, mul -> res=(0,7'h01,15'h1000) (2.25); flags 0; idle high exactly 18 edges after the start edge.
- A=(0,7'h01,15'h4000) 3.0, B=(1,7'h00,15'h4000) -1.5, div -> res=(1,7'h01,15'h0000) (-2.0); flags 0; latency 19.
- A=B=(0,7'h3E,0), mul -> res_e=7'h3F, res_m=0, overflow_flag=1.
- A=(0,7'h41,0) 2^-63, B=(0,7'h7F,0) 2^-1, mul -> res_e=7'h40, res_s=0, zero_flag=1, underflow_flag=1.
- A=1.0, B=(0,7'h40,x), div -> infinity, overflow_flag=1, idle high 1 edge after start. 0/0 -> zero encoding with zero_flag=1 and overflow_flag=1.
- Start mul, pulse div at edge 5, drop rst_n at edge 10 -> the div pulse is ignored; reset returns idle=1 and all outputs 0 immediately. A fresh mul after release completes normally.
